// File: rtl/context_pkg.sv
// Shared constants and helpers for the KxK neighbourhood generator.
//   DE_BIT/HS_BIT/VS_BIT : positions of the control bits inside a tap word
//   tap_w(pix_w)         : tap word width, {pixel, de, h_sync, v_sync}
//   win_idx(r, c, win)   : flattened tap index of window tap (r, c)
package context_pkg;

  localparam int unsigned DE_BIT = 2;
  localparam int unsigned HS_BIT = 1;
  localparam int unsigned VS_BIT = 0;

  function automatic int unsigned tap_w(input int unsigned pix_w);
    return pix_w + 3;
  endfunction

  function automatic int unsigned win_idx(input int unsigned r,
                                          input int unsigned c,
                                          input int unsigned win);
    return r * win + c;
  endfunction

endpackage

// File: rtl/line_delay_ram.sv
// Fixed delay of DEPTH ce-enabled edges: a circular RAM of DEPTH-1 words
// plus one registered read stage.
//   clk, rst_n : clock, async active-low reset (clears pointer, fill, dout)
//   ce         : advance enable; all state holds when low
//   din        : word entering the delay
//   dout       : word delayed by DEPTH ce-enabled edges (0 until RAM is filled)
module line_delay_ram #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // The output register supplies one edge of the delay, the RAM the rest.
  localparam int unsigned RAM_D  = DEPTH - 1;
  localparam int unsigned PTR_W  = (RAM_D > 1) ? $clog2(RAM_D) : 1;
  localparam int unsigned FILL_W = $clog2(RAM_D + 1);

  logic [WIDTH-1:0]  mem [RAM_D];
  logic [PTR_W-1:0]  ptr;
  logic [FILL_W-1:0] fill;
  logic              filled_c;

  // Every RAM word has been written since reset once fill saturates.
  assign filled_c = (fill == FILL_W'(RAM_D));

  // RAM array: no reset, stale words are masked by the fill counter.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem[ptr] <= din;
    end
  end

  // Pointer, fill counter and gated read register (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      fill <= '0;
      dout <= '0;
    end else if (ce) begin
      dout <= filled_c ? mem[ptr] : '0;
      ptr  <= (ptr == PTR_W'(RAM_D - 1)) ? '0 : ptr + PTR_W'(1);
      if (!filled_c) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/context_nxn.sv
// Parametrised WIN x WIN neighbourhood generator for the video filter chain.
//   clk, rst_n        : pixel clock, async active-low reset
//   ce                : advance enable; all state holds when low
//   pixel_in, de_in,
//   h_sync_in,
//   v_sync_in         : one pixel plus timing per enabled clock
//   window            : all taps, tap (r,c) at [(r*WIN+c)*TAP_W +: TAP_W]
//                       (r=0 newest line, c=0 newest pixel)
//   center            : tap (WIN/2, WIN/2)
//   context_valid     : AND of the de bit across every tap
module context_nxn
  import context_pkg::*;
#(
  parameter  int unsigned PIX_W  = 8,
  parameter  int unsigned H_SIZE = 1650,
  parameter  int unsigned WIN    = 3,
  localparam int unsigned TAP_W  = tap_w(PIX_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic [PIX_W-1:0]         pixel_in,
  input  logic                     de_in,
  input  logic                     h_sync_in,
  input  logic                     v_sync_in,
  output logic [WIN*WIN*TAP_W-1:0] window,
  output logic [TAP_W-1:0]         center,
  output logic                     context_valid
);

  // Line buffer delay so that vertical neighbours are H_SIZE edges apart.
  localparam int unsigned LB_D = H_SIZE - WIN;

  // Reject unsupported geometries at elaboration time.
  if ((WIN % 2) == 0 || WIN < 3 || WIN > 7 || H_SIZE < WIN + 2) begin : g_bad_params
    $fatal(1, "context_nxn: illegal parameters WIN=%0d H_SIZE=%0d", WIN, H_SIZE);
  end

  logic [TAP_W-1:0] tap_q  [WIN][WIN];
  logic [TAP_W-1:0] row_in [WIN];
  logic [TAP_W-1:0] lb_out [WIN-1];
  logic             valid_c;

  assign row_in[0] = {pixel_in, de_in, h_sync_in, v_sync_in};

  // Each line buffer feeds from the oldest tap of the row above it.
  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    line_delay_ram #(
      .WIDTH (TAP_W),
      .DEPTH (LB_D)
    ) u_line_delay_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .din   (tap_q[k][WIN-1]),
      .dout  (lb_out[k])
    );
    assign row_in[k+1] = lb_out[k];
  end

  // Tap shift registers, one row per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          tap_q[r][c] <= '0;
        end
      end
    end else if (ce) begin
      for (int r = 0; r < WIN; r++) begin
        tap_q[r][0] <= row_in[r];
        for (int c = 1; c < WIN; c++) begin
          tap_q[r][c] <= tap_q[r][c-1];
        end
      end
    end
  end

  // Flatten taps and AND the de bits; no extra stage so valid aligns with taps.
  always_comb begin
    window  = '0;
    valid_c = 1'b1;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        window[win_idx(r, c, WIN)*TAP_W +: TAP_W] = tap_q[r][c];
        valid_c = valid_c & tap_q[r][c][DE_BIT];
      end
    end
  end

  assign center        = tap_q[WIN/2][WIN/2];
  assign context_valid = valid_c;

endmodule

// File: tb/tb_context_nxn.sv
// Self-checking bench for context_nxn: a WIN=3/H_SIZE=16 and a WIN=5/H_SIZE=20
// instance share stimulus; expectations come from an input history queue
// indexed by the tap latency r*H_SIZE + c.
module tb_context_nxn;

  localparam int unsigned PW  = 8;
  localparam int unsigned TW  = PW + 3;
  localparam int unsigned W3  = 3;
  localparam int unsigned H3  = 16;
  localparam int unsigned W5  = 5;
  localparam int unsigned H5  = 20;
  localparam int unsigned N3  = W3 * W3 * TW;
  localparam int unsigned N5  = W5 * W5 * TW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic [PW-1:0] pixel_in;
  logic          de_in, h_sync_in, v_sync_in;
  logic [N3-1:0] window3;
  logic [TW-1:0] center3;
  logic          context_valid3;
  logic [N5-1:0] window5;
  logic [TW-1:0] center5;
  logic          context_valid5;

  int tests = 0;
  int fails = 0;

  logic [TW-1:0] hist [$];
  logic [N3-1:0] prev_w3;
  logic [N5-1:0] prev_w5;
  logic [TW-1:0] prev_c3, prev_c5;
  logic          prev_v3, prev_v5;

  always #5 clk = ~clk;

  context_nxn #(.PIX_W(PW), .H_SIZE(H3), .WIN(W3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pixel_in(pixel_in), .de_in(de_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .window(window3), .center(center3), .context_valid(context_valid3)
  );

  context_nxn #(.PIX_W(PW), .H_SIZE(H5), .WIN(W5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pixel_in(pixel_in), .de_in(de_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .window(window5), .center(center5), .context_valid(context_valid5)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: tap (r,c) holds the sample presented r*h+c edges before the newest.
  function automatic logic [TW-1:0] exp_tap(input int r, input int c, input int h);
    int idx;
    idx = hist.size() - 1 - (r * h + c);
    return (idx >= 0) ? hist[idx] : '0;
  endfunction

  task automatic check_outputs(input bit adv);
    logic [N3-1:0] e3;
    logic [N5-1:0] e5;
    logic          v3, v5;
    logic [TW-1:0] t;
    e3 = '0; e5 = '0; v3 = 1'b1; v5 = 1'b1;
    for (int r = 0; r < int'(W3); r++) begin
      for (int cc = 0; cc < int'(W3); cc++) begin
        t = exp_tap(r, cc, H3);
        e3[(r*W3+cc)*TW +: TW] = t;
        v3 = v3 & t[2];
      end
    end
    for (int r = 0; r < int'(W5); r++) begin
      for (int cc = 0; cc < int'(W5); cc++) begin
        t = exp_tap(r, cc, H5);
        e5[(r*W5+cc)*TW +: TW] = t;
        v5 = v5 & t[2];
      end
    end
    chk("window3", window3, e3);
    chk("center3", center3, exp_tap(1, 1, H3));
    chk("valid3", context_valid3, v3);
    chk("window5", window5, e5);
    chk("center5", center5, exp_tap(2, 2, H5));
    chk("valid5", context_valid5, v5);
    if (!adv) begin
      chk("hold_w3", window3, prev_w3);
      chk("hold_c3", center3, prev_c3);
      chk("hold_v3", context_valid3, prev_v3);
      chk("hold_w5", window5, prev_w5);
      chk("hold_c5", center5, prev_c5);
      chk("hold_v5", context_valid5, prev_v5);
    end
    prev_w3 = window3; prev_c3 = center3; prev_v3 = context_valid3;
    prev_w5 = window5; prev_c5 = center5; prev_v5 = context_valid5;
  endtask

  // Drive one clock of stimulus, record it if enabled, check at the falling edge.
  task automatic cycle(input bit c, input logic [PW-1:0] p, input bit d, input bit h, input bit v);
    ce = c; pixel_in = p; de_in = d; h_sync_in = h; v_sync_in = v;
    @(posedge clk);
    if (c) hist.push_back({p, d, h, v});
    @(negedge clk);
    check_outputs(c);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_w3"}, window3, '0);
    chk({tag, "_c3"}, center3, '0);
    chk({tag, "_v3"}, context_valid3, '0);
    chk({tag, "_w5"}, window5, '0);
    chk({tag, "_c5"}, center5, '0);
    chk({tag, "_v5"}, context_valid5, '0);
  endtask

  // Ramp with de=1 starting right after reset; pixel = edge index.
  task automatic ramp(input string tag, input int n);
    int f3, f5;
    f3 = -1; f5 = -1;
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, PW'(k), 1'b1, 1'($urandom), 1'($urandom));
      if (f3 < 0 && context_valid3) f3 = k + 1;
      if (f5 < 0 && context_valid5) f5 = k + 1;
      if (k + 1 == 40) begin
        chk({tag, "_ctr3_pix"}, center3[TW-1:3], PW'(40 - 18));
        chk({tag, "_t00_pix"}, window3[3 +: PW], PW'(40 - 1));
        chk({tag, "_t22_pix"}, window3[8*TW+3 +: PW], PW'(40 - 35));
      end
      if (k + 1 == 90) begin
        chk({tag, "_w5_t22_pix"}, window5[12*TW+3 +: PW], PW'(90 - 43));
        chk({tag, "_w5_t44_pix"}, window5[24*TW+3 +: PW], PW'(90 - 85));
      end
    end
    chk({tag, "_rise3"}, f3, 35);
    chk({tag, "_rise5"}, f5, 85);
  endtask

  initial begin
    int vcnt [6];
    rst_n = 1'b0; ce = 1'b0; pixel_in = '0;
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
    #3;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    ramp("ramp", 90);

    // Short async reset pulse mid-line, away from any clock edge.
    ce = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    #3 rst_n = 1'b1;
    hist.delete();
    ramp("postrst", 90);

    // Blanking: de high for 12 of every 16 clocks.
    for (int i = 0; i < 6; i++) vcnt[i] = 0;
    for (int k = 0; k < 96; k++) begin
      cycle(1'b1, PW'($urandom), (k % 16) < 12, 1'($urandom), 1'($urandom));
      if (context_valid3) vcnt[k/16]++;
    end
    for (int i = 3; i < 6; i++) chk("blank_line_valid", vcnt[i], 10);

    // Stall pattern 1,0,0,1; junk inputs on stalled cycles must be ignored.
    for (int k = 0; k < 200; k++) begin
      cycle((k % 4) == 0 || (k % 4) == 3, PW'($urandom), ($urandom % 8) != 0,
            1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/context_nxn.md
Name: context_nxn

Overview:
- Parametrised K×K neighbourhood generator for the video filter chain. Successor to the fixed 3×3 context block.
- Accepts one pixel plus de/h_sync/v_sync per clock.
- Keeps WIN−1 internal line buffers sized from parameters; no hard-coded line length.
- Exposes the full WIN×WIN tap window, a dedicated center tap, and an all-taps-valid flag.
- Adds a clock-enable stall and asynchronous reset, which the fixed-size generation lacks.

Parameters:
- PIX_W, 8: pixel width in bits.
- H_SIZE, 1650: total line length in clocks, including blanking.
- WIN, 3: window size. Must be odd, 3..7.
- TAP_W (derived, localparam), PIX_W+3: tap word width {pixel, de, h_sync, v_sync}.

Ports:
- clk, in, 1: pixel clock. All logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- ce, in, 1: advance enable. When 0, all state holds.
- pixel_in, in, PIX_W: input pixel.
- de_in, in, 1: data enable.
- h_sync_in, in, 1: horizontal sync.
- v_sync_in, in, 1: vertical sync.
- window, out, WIN*WIN*TAP_W: flattened taps. Tap (r,c) sits at bits [(r*WIN+c)*TAP_W +: TAP_W].
- center, out, TAP_W: alias of tap (WIN/2, WIN/2).
- context_valid, out, 1: AND of the de bit of all WIN*WIN taps.

Behaviour:
- Tap word layout: bit 0 = v_sync, bit 1 = h_sync, bit 2 = de, bits [TAP_W-1:3] = pixel.
- Tap indexing: r = row, 0 = newest line (bottom). c = column, 0 = newest pixel (right).
- Row 0 shift: on each rising edge with ce=1, tap(0,0) <= {pixel_in, de_in, h_sync_in, v_sync_in}, and tap(0,c) <= tap(0,c-1).
- Line buffers: line buffer k (k = 0..WIN-2) takes tap(k,WIN-1) as input. It is a fixed delay of D = H_SIZE-WIN ce-enabled edges. Then tap(k+1,0) <= buffer k output, and tap(k+1,c) <= tap(k+1,c-1).
- Result: vertical neighbours are exactly H_SIZE ce-enabled edges apart.
- Latency: a sample presented at edge e appears in tap(r,c) after r*H_SIZE + c + 1 ce-enabled edges.
  - center latency = (WIN/2)*H_SIZE + WIN/2 + 1.
  - For WIN=3, H_SIZE=1650, that is 1652.
- Stall (ce=0):
  - no tap, line-buffer pointer or RAM write changes;
  - outputs hold their values;
  - inputs are ignored that cycle, so upstream must hold data.
- Line buffer implementation: circular RAM of depth D with one pointer.
  - On ce=1: read addr ptr, write addr ptr (read-before-write), ptr <= (ptr==D-1) ? 0 : ptr+1.
  - Registered read output counts inside D. RAM depth is therefore D-1 with one output register; the total must equal D exactly.
- Reset (async, rst_n=0):
  - all taps, line-buffer output registers and pointers clear to 0 immediately;
  - window=0, center=0, context_valid=0.
  - RAM contents are not cleared. Any RAM word not rewritten since reset is masked by read-data gating: a per-buffer fill counter forces output to 0 until D writes have occurred. The counter saturates.
- Reset mid-frame: after release, context_valid stays 0 until all WIN*WIN taps have again seen de=1. No stale de from before reset may assert it.
- context_valid is combinational from the tap registers, with no extra register stage, so it aligns with window/center.
- Width rules: no arithmetic on data. Pointers and fill counters are $clog2(H_SIZE) bits wide.
- Elaboration checks: fatal error if WIN is even, WIN < 3, or H_SIZE < WIN+2.

Decomposition:
- Package context_pkg: DE_BIT=2, HS_BIT=1, VS_BIT=0, function tap_w(pix_w), function win_idx(r,c,win).
- Sub-module line_delay_ram:
  - parameters WIDTH, DEPTH;
  - ports clk, rst_n, ce, din, dout;
  - contains the circular RAM, pointer and fill-masking counter;
  - instantiated WIN-1 times by a generate loop.

Test Plan:
- Latency (WIN=3, H_SIZE=16, PIX_W=8): pixel value = running index 0..255 with de=1 continuously, ce=1.
  - At every cycle, center pixel = index-18, tap(0,0) = index-1, tap(2,2) = index-35.
  - context_valid rises exactly 35 edges after the first de.
- Blanking (WIN=3, H_SIZE=16): de high for 12 of every 16 clocks.
  - context_valid is 0 whenever any tap column carries de=0.
  - Per line, exactly 10 valid cycles once 3 lines are filled.
- Stall: toggle ce with pattern 1,0,0,1 repeating.
  - Window contents are identical to the ce=1 run, indexed by ce-enabled edge count.
  - No output changes on ce=0 cycles.
- Async reset: assert rst_n=0 mid-line, for less than one clock, at a non-edge time.
  - All outputs are 0 immediately.
  - After release with de=1 continuous, context_valid stays 0 for the first 35 edges, despite stale RAM data.
- WIN=5, H_SIZE=20: ramp input.
  - tap(2,2) = index-43; tap(4,4) = index-85.
  - Sync bits track the pixel through all taps.
- Elaboration: WIN=4 and H_SIZE=4 (with WIN=3) each fail elaboration with a fatal message.
